viterbi_ctrl_fsm: RTL and testbench

Registered, parametrised control FSM for the Viterbi decoder datapath. It replaces the older combinational next-state block with a state register, internal index, symbol and traceback counters, and decoded strobes. It also generalises the trellis state count and the traceback depth. It sits between the host start/abort interface and the BM/ACS/traceback/output-stack datapath.

---
 rtl/viterbi_ctrl_pkg.sv | 23 ++
 rtl/viterbi_idx_cnt.sv | 46 ++++
 rtl/viterbi_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_viterbi_ctrl_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_ctrl_pkg.sv
// Shared types for the Viterbi decoder control path: the 4-bit state encoding
// and the index-width helper used to size the trellis index.
package viterbi_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_LOAD_PM   = 4'd2,
        S_SYM_FETCH = 4'd3,
        S_BM        = 4'd4,
        S_ACS       = 4'd5,
        S_MERGE     = 4'd6,
        S_TB_START  = 4'd7,
        S_TB_SEL    = 4'd8,
        S_TRACEBACK = 4'd9,
        S_OUTPUT    = 4'd10
    } ctrl_state_e;

    function automatic int IDX_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/viterbi_idx_cnt.sv
// Trellis index and processed-symbol counter; the FSM drives clear, index
// increment, index wrap and symbol increment.
module viterbi_idx_cnt
    import viterbi_ctrl_pkg::*;
#(
    parameter int NUM_ST = 11,
    parameter int SYM_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     idx_inc_i,
    input  logic                     idx_wrap_i,
    input  logic                     sym_inc_i,
    output logic [IDX_W(NUM_ST)-1:0] idx_o,
    output logic [SYM_W-1:0]         sym_cnt_o,
    output logic                     last_o
);
    localparam int IW = IDX_W(NUM_ST);

    logic [IW-1:0]    idx_q;
    logic [SYM_W-1:0] sym_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sym_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
            sym_q <= '0;
        end else begin
            if (idx_wrap_i)
                idx_q <= '0;
            else if (idx_inc_i)
                idx_q <= idx_q + 1'b1;
            // Symbol count wraps naturally modulo 2^SYM_W.
            if (sym_inc_i)
                sym_q <= sym_q + 1'b1;
        end
    end

    assign last_o    = (idx_q == IW'(NUM_ST - 1));
    assign idx_o     = idx_q;
    assign sym_cnt_o = sym_q;

endmodule

// File: rtl/viterbi_ctrl_fsm.sv
// Registered control FSM for the Viterbi datapath (BM/ACS/traceback/output).
// Optional traceback watchdog enabled by defining VITERBI_TIMEOUT_EN.
module viterbi_ctrl_fsm
    import viterbi_ctrl_pkg::*;
#(
    parameter int NUM_ST   = 11,
    parameter int KEY_W    = 8,
    parameter int TB_DEPTH = 64,
    parameter int SYM_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     error,
    input  logic                     multiple_source,
    input  logic                     endline,
    input  logic [KEY_W-1:0]         key,
    input  logic                     stack_empty,
    output logic [3:0]               state,
    output logic [IDX_W(NUM_ST)-1:0] idx,
    output logic [SYM_W-1:0]         sym_cnt,
    output logic                     busy,
    output logic                     pm_init_we,
    output logic                     acs_en,
    output logic                     tb_step,
    output logic                     stack_pop,
    output logic                     done,
    output logic                     err_abort
);
    localparam int TB_W = $clog2(TB_DEPTH + 1);

    ctrl_state_e     state_q, state_d;
    logic [TB_W-1:0] tb_cnt_q, tb_cnt_d;
    logic            cnt_clr, idx_inc, idx_wrap, sym_inc, idx_last;
    logic            key_nz, wd_hit, abort_d, done_d;

    assign key_nz = |key;

`ifdef VITERBI_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_run;

    assign wd_run = (state_q == S_TB_SEL) || (state_q == S_TRACEBACK) ||
                    (state_q == S_OUTPUT);
    assign wd_hit = wd_run && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_q <= '0;
        else if (state_q == S_TB_START)
            wd_q <= '0;
        else if (wd_run)
            wd_q <= wd_q + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        tb_cnt_d = tb_cnt_q;
        cnt_clr  = 1'b0;
        idx_inc  = 1'b0;
        idx_wrap = 1'b0;
        sym_inc  = 1'b0;
        abort_d  = 1'b0;
        done_d   = 1'b0;
        if (wd_hit) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE:      if (start) state_d = S_INIT;
                S_INIT: begin
                    cnt_clr = 1'b1;
                    state_d = S_LOAD_PM;
                end
                S_LOAD_PM: begin
                    if (error) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else if (idx_last) begin
                        idx_wrap = 1'b1;
                        state_d  = S_SYM_FETCH;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
                S_SYM_FETCH: state_d = S_BM;
                S_BM: begin
                    state_d = error ? S_IDLE : S_ACS;
                    abort_d = error;
                end
                S_ACS: begin
                    if (error) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else if (multiple_source) begin
                        state_d = S_MERGE;
                    end else if (endline) begin
                        state_d = S_TB_START;
                    end else if (idx_last) begin
                        idx_wrap = 1'b1;
                        sym_inc  = 1'b1;
                        state_d  = S_SYM_FETCH;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
                S_MERGE: begin
                    if (idx_last) begin
                        idx_wrap = 1'b1;
                        sym_inc  = 1'b1;
                        state_d  = S_SYM_FETCH;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = S_ACS;
                    end
                end
                S_TB_START: begin
                    tb_cnt_d = TB_W'(TB_DEPTH);
                    state_d  = S_TB_SEL;
                end
                S_TB_SEL:    state_d = S_TRACEBACK;
                S_TRACEBACK: begin
                    // A zero key marks the traceback origin; running out of
                    // budget before reaching it means the survivor path is bad.
                    if (!key_nz) begin
                        state_d = S_OUTPUT;
                    end else if (tb_cnt_q == '0) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else begin
                        tb_cnt_d = tb_cnt_q - 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (stack_empty) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            tb_cnt_q <= tb_cnt_d;
        end
    end

    viterbi_idx_cnt #(
        .NUM_ST (NUM_ST),
        .SYM_W  (SYM_W)
    ) u_idx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .idx_inc_i  (idx_inc),
        .idx_wrap_i (idx_wrap),
        .sym_inc_i  (sym_inc),
        .idx_o      (idx),
        .sym_cnt_o  (sym_cnt),
        .last_o     (idx_last)
    );

    // done/err_abort mark the cycle in which the return to IDLE is decided.
    assign state      = state_q;
    assign busy       = (state_q != S_IDLE);
    assign pm_init_we = (state_q == S_LOAD_PM);
    assign acs_en     = (state_q == S_ACS);
    assign tb_step    = (state_q == S_TRACEBACK) && key_nz;
    assign stack_pop  = (state_q == S_OUTPUT) && !stack_empty;
    assign done       = done_d;
    assign err_abort  = abort_d;

endmodule

// File: tb/tb_viterbi_ctrl_fsm.sv
// Self-checking bench for viterbi_ctrl_fsm: cycle-level reference model plus
// directed sequences with hand-computed expectations.
module tb_viterbi_ctrl_fsm;

    localparam int NUM_ST   = 11;
    localparam int KEY_W    = 8;
    localparam int TB_DEPTH = 4;
    localparam int SYM_W    = 16;
    localparam int TIMEOUT  = 8;
`ifdef VITERBI_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_INIT = 1, P_LOAD = 2, P_FETCH = 3, P_BM = 4,
                   P_ACS = 5, P_MERGE = 6, P_TBSTART = 7, P_TBSEL = 8,
                   P_TRACE = 9, P_OUTPUT = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0, error = 1'b0, multiple_source = 1'b0;
    logic             endline = 1'b0, stack_empty = 1'b0;
    logic [KEY_W-1:0] key = '0;
    logic [3:0]       state;
    logic [3:0]       idx;
    logic [SYM_W-1:0] sym_cnt;
    logic             busy, pm_init_we, acs_en, tb_step, stack_pop, done, err_abort;

    int checks = 0;
    int failures = 0;

    int m_st = 0, m_idx = 0, m_sym = 0, m_tb = 0, m_wd = 0;

    viterbi_ctrl_fsm #(
        .NUM_ST(NUM_ST), .KEY_W(KEY_W), .TB_DEPTH(TB_DEPTH),
        .SYM_W(SYM_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .error(error),
        .multiple_source(multiple_source), .endline(endline), .key(key),
        .stack_empty(stack_empty), .state(state), .idx(idx), .sym_cnt(sym_cnt),
        .busy(busy), .pm_init_we(pm_init_we), .acs_en(acs_en), .tb_step(tb_step),
        .stack_pop(stack_pop), .done(done), .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_watch(input int s);
        return (s == P_TBSEL) || (s == P_TRACE) || (s == P_OUTPUT);
    endfunction

    // Reference model: one step of the block-level decode rules per clock.
    task automatic model_step();
        int nxt;
        nxt = m_st;
        if (TO_EN && in_watch(m_st) && (m_wd + 1 >= TIMEOUT)) nxt = P_IDLE;
        else case (m_st)
            P_IDLE:    if (start) nxt = P_INIT;
            P_INIT:    begin m_idx = 0; m_sym = 0; nxt = P_LOAD; end
            P_LOAD:    if (error) nxt = P_IDLE;
                       else if (m_idx == NUM_ST - 1) begin m_idx = 0; nxt = P_FETCH; end
                       else m_idx++;
            P_FETCH:   nxt = P_BM;
            P_BM:      nxt = error ? P_IDLE : P_ACS;
            P_ACS:     if (error) nxt = P_IDLE;
                       else if (multiple_source) nxt = P_MERGE;
                       else if (endline) nxt = P_TBSTART;
                       else if (m_idx == NUM_ST - 1) begin
                           m_idx = 0; m_sym = (m_sym + 1) % (1 << SYM_W); nxt = P_FETCH;
                       end else m_idx++;
            P_MERGE:   if (m_idx == NUM_ST - 1) begin
                           m_idx = 0; m_sym = (m_sym + 1) % (1 << SYM_W); nxt = P_FETCH;
                       end else begin m_idx++; nxt = P_ACS; end
            P_TBSTART: begin m_tb = TB_DEPTH; nxt = P_TBSEL; end
            P_TBSEL:   nxt = P_TRACE;
            P_TRACE:   if (key == 0) nxt = P_OUTPUT;
                       else if (m_tb == 0) nxt = P_IDLE;
                       else m_tb--;
            P_OUTPUT:  if (stack_empty) nxt = P_IDLE;
            default:   nxt = P_IDLE;
        endcase
        if (m_st == P_TBSTART) m_wd = 0;
        else if (in_watch(m_st)) m_wd++;
        m_st = nxt;
    endtask

    task automatic compare_model();
        bit to_hit, e_abort, e_done;
        to_hit  = TO_EN && in_watch(m_st) && (m_wd + 1 >= TIMEOUT);
        e_abort = to_hit || (error && (m_st == P_LOAD || m_st == P_BM || m_st == P_ACS)) ||
                  (m_st == P_TRACE && key != 0 && m_tb == 0);
        e_done  = (m_st == P_OUTPUT) && stack_empty && !to_hit;
        chk("mdl_state", 32'(state), m_st);
        chk("mdl_idx", 32'(idx), m_idx);
        chk("mdl_sym_cnt", 32'(sym_cnt), m_sym);
        chk("mdl_busy", 32'(busy), 32'(m_st != P_IDLE));
        chk("mdl_pm_init_we", 32'(pm_init_we), 32'(m_st == P_LOAD));
        chk("mdl_acs_en", 32'(acs_en), 32'(m_st == P_ACS));
        chk("mdl_tb_step", 32'(tb_step), 32'(m_st == P_TRACE && key != 0));
        chk("mdl_stack_pop", 32'(stack_pop), 32'(m_st == P_OUTPUT && !stack_empty));
        chk("mdl_done", 32'(done), 32'(e_done));
        chk("mdl_err_abort", 32'(err_abort), 32'(e_abort));
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin m_st = 0; m_idx = 0; m_sym = 0; m_tb = 0; m_wd = 0; end
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_model();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_to_acs();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
        repeat (NUM_ST) cyc();
        cyc(); cyc();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_sym_cnt", 32'(sym_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc();

        // Start and path-metric load sweep
        start = 1'b1; cyc();
        chk("start_init", 32'(state), P_INIT);
        start = 1'b0; cyc();
        for (int k = 0; k < NUM_ST; k++) begin
            chk("load_state", 32'(state), P_LOAD);
            chk("load_idx", 32'(idx), k);
            chk("load_we", 32'(pm_init_we), 1);
            cyc();
        end
        chk("load_exit", 32'(state), P_FETCH);

        // Two full symbols
        for (int s = 1; s <= 2; s++) begin
            cyc(); chk("bm_state", 32'(state), P_BM);
            cyc();
            for (int k = 0; k < NUM_ST; k++) begin
                chk("acs_idx", 32'(idx), k);
                chk("acs_en", 32'(acs_en), 1);
                cyc();
            end
            chk("sym_fetch", 32'(state), P_FETCH);
            chk("sym_cnt", 32'(sym_cnt), s);
        end

        // Merge mid-symbol and on the last index
        cyc(); cyc();
        repeat (4) cyc();
        multiple_source = 1'b1; cyc();
        chk("merge_state", 32'(state), P_MERGE);
        chk("merge_idx", 32'(idx), 4);
        multiple_source = 1'b0; cyc();
        chk("merge_ret", 32'(state), P_ACS);
        chk("merge_ret_idx", 32'(idx), 5);
        repeat (5) cyc();
        chk("acs_idx10", 32'(idx), 10);
        multiple_source = 1'b1; cyc();
        chk("merge_last", 32'(state), P_MERGE);
        multiple_source = 1'b0; cyc();
        chk("merge_fetch", 32'(state), P_FETCH);
        chk("merge_sym", 32'(sym_cnt), 3);

        // Error in BM
        cyc();
        error = 1'b1; #1;
        chk("bm_err_abort", 32'(err_abort), 1);
        cyc(); error = 1'b0; #1;
        chk("bm_err_idle", 32'(state), P_IDLE);
        chk("bm_err_pulse", 32'(err_abort), 0);

        // Error in ACS beats endline
        start_to_acs();
        error = 1'b1; endline = 1'b1; #1;
        chk("acs_err_abort", 32'(err_abort), 1);
        cyc(); error = 1'b0; endline = 1'b0; #1;
        chk("acs_err_idle", 32'(state), P_IDLE);

        // Normal traceback and output
        start_to_acs();
        endline = 1'b1; cyc();
        chk("tb_start", 32'(state), P_TBSTART);
        endline = 1'b0; cyc();
        chk("tb_sel", 32'(state), P_TBSEL);
        key = 8'd5; cyc();
        for (int i = 0; i < 3; i++) begin
            chk("tb_state", 32'(state), P_TRACE);
            chk("tb_step", 32'(tb_step), 1);
            cyc();
        end
        key = 8'd0; #1;
        chk("tb_step_off", 32'(tb_step), 0);
        cyc();
        chk("out_state", 32'(state), P_OUTPUT);
        for (int i = 0; i < 2; i++) begin
            chk("out_pop", 32'(stack_pop), 1);
            cyc();
        end
        stack_empty = 1'b1; start = 1'b1; #1;
        chk("done_pulse", 32'(done), TO_EN ? 0 : 1);
        chk("done_no_abort", 32'(err_abort), TO_EN ? 1 : 0);
        cyc(); start = 1'b0; stack_empty = 1'b0; #1;
        chk("done_idle", 32'(state), P_IDLE);
        chk("done_low", 32'(done), 0);

        // Runaway traceback: TB_DEPTH=4 gives five TRACEBACK cycles
        start_to_acs();
        endline = 1'b1; cyc();
        endline = 1'b0; cyc();
        key = 8'd7; cyc();
        for (int i = 0; i < 5; i++) begin
            chk("run_state", 32'(state), P_TRACE);
            chk("run_abort", 32'(err_abort), (i == 4) ? 1 : 0);
            cyc();
        end
        chk("run_idle", 32'(state), P_IDLE);
        key = 8'd0;

        // Output stall: waits forever unless the watchdog is built in
        start_to_acs();
        endline = 1'b1; cyc();
        endline = 1'b0; cyc();
        cyc(); cyc();
        repeat (12) cyc();
        chk("stall_state", 32'(state), TO_EN ? P_IDLE : P_OUTPUT);
        stack_empty = 1'b1; #1;
        chk("stall_done", 32'(done), TO_EN ? 0 : 1);
        cyc(); stack_empty = 1'b0;

        // Reset in the middle of ACS
        start_to_acs();
        cyc(); cyc();
        #1 rst_n = 1'b0; #1;
        chk("mid_rst_state", 32'(state), P_IDLE);
        chk("mid_rst_idx", 32'(idx), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_abort", 32'(err_abort), 0);
        cyc(); rst_n = 1'b1; cyc();
        chk("post_rst_state", 32'(state), P_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
